// File: rtl/mem_arb_pkg.sv
// Shared encodings for the three-port SRAM arbiter: FSM states and requester IDs.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef logic [1:0] port_id_t;

    localparam port_id_t P_VID    = 2'd0;
    localparam port_id_t P_DAP    = 2'd1;
    localparam port_id_t P_CPU    = 2'd2;
    localparam port_id_t GNT_NONE = 2'd3;

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester-side bundle: video read port plus two read/write ports, each with a one-cycle ack.
interface mem_arbiter_if #(
    parameter int ADDR_W = 24
);
    logic [ADDR_W-1:0] p0_addr;
    logic              p0_rq;
    logic              p0_ack;
    logic [15:0]       p0_rd;

    logic [ADDR_W-1:0] p1_addr;
    logic [15:0]       p1_d_wr;
    logic              p1_w_rq;
    logic              p1_r_rq;
    logic              p1_ack;
    logic [15:0]       p1_d_rd;

    logic [ADDR_W-1:0] p2_addr;
    logic [15:0]       p2_d_wr;
    logic              p2_w_rq;
    logic              p2_r_rq;
    logic              p2_ack;
    logic [15:0]       p2_d_rd;

    modport master (
        output p0_addr, p0_rq,
        output p1_addr, p1_d_wr, p1_w_rq, p1_r_rq,
        output p2_addr, p2_d_wr, p2_w_rq, p2_r_rq,
        input  p0_ack, p0_rd, p1_ack, p1_d_rd, p2_ack, p2_d_rd
    );

    modport slave (
        input  p0_addr, p0_rq,
        input  p1_addr, p1_d_wr, p1_w_rq, p1_r_rq,
        input  p2_addr, p2_d_wr, p2_w_rq, p2_r_rq,
        output p0_ack, p0_rd, p1_ack, p1_d_rd, p2_ack, p2_d_rd
    );
endinterface

// File: rtl/mem_arb_pick.sv
// Combinational winner select: video first unless its burst limit is hit while 1/2 wait.
// Ports 1 and 2 share the remaining slots round-robin via rr_i (0 favours port 1).
module mem_arb_pick
    import mem_arb_pkg::*;
(
    input  logic [2:0] pend_i,
    input  logic       rr_i,
    input  logic       burst_lim_i,
    output port_id_t   win_o,
    output logic       win_vld_o
);

    always_comb begin
        win_o     = GNT_NONE;
        win_vld_o = |pend_i;
        if (pend_i[0] && !(burst_lim_i && (pend_i[1] || pend_i[2]))) begin
            win_o = P_VID;
        end else if (pend_i[1] && (!pend_i[2] || !rr_i)) begin
            win_o = P_DAP;
        end else if (pend_i[2]) begin
            win_o = P_CPU;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Three-requester async SRAM arbiter: IDLE -> ACC (WAIT+1 clk) -> DONE (ack), WAIT+3 clk per access.
// Requesters hold until their one-cycle ack; IDLE between accesses separates bus turnarounds.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W   = 24,
    parameter int SRAM_AW  = 19,
    parameter int WAIT     = 1,
    parameter int P0_BURST = 4
)(
    input  logic               clk,
    input  logic               rst_n,
    mem_arbiter_if.slave       bus,
    output logic [SRAM_AW-1:0] sram_a,
    inout  wire  [15:0]        sram_d,
    output logic               sram_ce_n,
    output logic               sram_oe_n,
    output logic               sram_we_n,
    output logic [1:0]         gnt
);

    localparam logic [2:0] WAIT_C  = 3'(WAIT);
    localparam logic [3:0] BURST_C = 4'(P0_BURST);

    state_t             state_q, state_d;
    port_id_t           port_q, port_d;
    logic [SRAM_AW-1:0] addr_q, addr_d;
    logic [15:0]        wdat_q, wdat_d;
    logic               wr_q, wr_d;
    logic [2:0]         cnt_q, cnt_d;
    logic               rr_q, rr_d;
    logic [3:0]         burst_q, burst_d;
    logic [15:0]        rd0_q, rd0_d, rd1_q, rd1_d, rd2_q, rd2_d;

    logic [2:0] pend;
    logic       burst_lim;
    port_id_t   win;
    logic       win_vld;
    logic       unused_addr_hi;

    assign pend = {bus.p2_w_rq | bus.p2_r_rq, bus.p1_w_rq | bus.p1_r_rq, bus.p0_rq};
    assign burst_lim = (burst_q == BURST_C);
    assign unused_addr_hi = ^{bus.p0_addr[ADDR_W-1:SRAM_AW], bus.p1_addr[ADDR_W-1:SRAM_AW],
                              bus.p2_addr[ADDR_W-1:SRAM_AW]};

    mem_arb_pick u_pick (
        .pend_i      (pend),
        .rr_i        (rr_q),
        .burst_lim_i (burst_lim),
        .win_o       (win),
        .win_vld_o   (win_vld)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            port_q  <= P_VID;
            addr_q  <= '0;
            wdat_q  <= '0;
            wr_q    <= 1'b0;
            cnt_q   <= '0;
            rr_q    <= 1'b0;
            burst_q <= '0;
            rd0_q   <= '0;
            rd1_q   <= '0;
            rd2_q   <= '0;
        end else begin
            state_q <= state_d;
            port_q  <= port_d;
            addr_q  <= addr_d;
            wdat_q  <= wdat_d;
            wr_q    <= wr_d;
            cnt_q   <= cnt_d;
            rr_q    <= rr_d;
            burst_q <= burst_d;
            rd0_q   <= rd0_d;
            rd1_q   <= rd1_d;
            rd2_q   <= rd2_d;
        end
    end

    always_comb begin
        state_d = state_q;
        port_d  = port_q;
        addr_d  = addr_q;
        wdat_d  = wdat_q;
        wr_d    = wr_q;
        cnt_d   = cnt_q;
        rr_d    = rr_q;
        burst_d = burst_q;
        rd0_d   = rd0_q;
        rd1_d   = rd1_q;
        rd2_d   = rd2_q;
        case (state_q)
            IDLE: begin
                if (win_vld) begin
                    state_d = ACC;
                    port_d  = win;
                    cnt_d   = WAIT_C;
                    case (win)
                        P_DAP: begin
                            addr_d = bus.p1_addr[SRAM_AW-1:0];
                            wdat_d = bus.p1_d_wr;
                            wr_d   = bus.p1_w_rq;
                        end
                        P_CPU: begin
                            addr_d = bus.p2_addr[SRAM_AW-1:0];
                            wdat_d = bus.p2_d_wr;
                            wr_d   = bus.p2_w_rq;
                        end
                        default: begin
                            addr_d = bus.p0_addr[SRAM_AW-1:0];
                            wr_d   = 1'b0;
                        end
                    endcase
                    // Burst only counts video grants that actually made port 1/2 wait.
                    if (win == P_VID) begin
                        burst_d = (pend[1] || pend[2]) ? (burst_lim ? burst_q : burst_q + 4'd1) : 4'd0;
                    end else begin
                        burst_d = 4'd0;
                        rr_d    = (win == P_DAP);
                    end
                end
            end
            ACC: begin
                if (cnt_q == 3'd0) begin
                    state_d = DONE;
                    if (!wr_q) begin
                        case (port_q)
                            P_VID:   rd0_d = sram_d;
                            P_DAP:   rd1_d = sram_d;
                            default: rd2_d = sram_d;
                        endcase
                    end
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Write data stays on the bus through DONE to cover SRAM data hold after we_n rises.
    assign sram_d    = (wr_q && (state_q == ACC || state_q == DONE)) ? wdat_q : 16'hzzzz;
    assign sram_a    = addr_q;
    assign sram_ce_n = !(state_q == ACC || state_q == DONE);
    assign sram_oe_n = !(state_q == ACC && !wr_q);
    assign sram_we_n = !(state_q == ACC && wr_q);
    assign gnt       = (state_q == IDLE) ? GNT_NONE : port_q;

    assign bus.p0_ack  = (state_q == DONE) && (port_q == P_VID);
    assign bus.p1_ack  = (state_q == DONE) && (port_q == P_DAP);
    assign bus.p2_ack  = (state_q == DONE) && (port_q == P_CPU);
    assign bus.p0_rd   = rd0_q;
    assign bus.p1_d_rd = rd1_q;
    assign bus.p2_d_rd = rd2_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: transaction-phase reference model with per-cycle compare plus directed scenarios.
module tb_mem_arbiter;

    localparam int ADDR_W   = 24;
    localparam int SRAM_AW  = 19;
    localparam int WAIT     = 1;
    localparam int P0_BURST = 4;

    logic               clk;
    logic               rst_n;
    logic [SRAM_AW-1:0] sram_a;
    wire  [15:0]        sram_d;
    logic               sram_ce_n, sram_oe_n, sram_we_n;
    logic [1:0]         gnt;

    mem_arbiter_if #(.ADDR_W(ADDR_W)) bus ();

    mem_arbiter #(
        .ADDR_W(ADDR_W), .SRAM_AW(SRAM_AW), .WAIT(WAIT), .P0_BURST(P0_BURST)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus.slave),
        .sram_a    (sram_a),
        .sram_d    (sram_d),
        .sram_ce_n (sram_ce_n),
        .sram_oe_n (sram_oe_n),
        .sram_we_n (sram_we_n),
        .gnt       (gnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // SRAM environment; an undriven bus floats high through the pullups.
    logic [15:0] sram_mem [0:4095];
    logic [15:0] sram_rdat;
    assign sram_rdat = sram_mem[sram_a[11:0]];
    assign sram_d = (!sram_ce_n && !sram_oe_n) ? sram_rdat : 16'hzzzz;
    for (genvar gi = 0; gi < 16; gi++) begin : g_pu
        pullup pu (sram_d[gi]);
    end
    always @(posedge clk) begin
        if (!sram_ce_n && !sram_we_n) sram_mem[sram_a[11:0]] <= sram_d;
    end

    // Reference model: m_phase 0 = waiting, 1..WAIT+1 = strobe cycles, WAIT+2 = ack cycle.
    int          m_phase;
    int          m_port;
    logic [18:0] m_addr;
    logic        m_wr;
    logic [15:0] m_data;
    int          m_next12;
    int          m_burst;
    logic [15:0] m_rd [3];
    logic [15:0] m_mem [0:4095];

    always @(posedge clk or negedge rst_n) begin : model
        bit p0, p1, p2;
        int w;
        if (!rst_n) begin
            m_phase  <= 0;
            m_port   <= 0;
            m_addr   <= '0;
            m_wr     <= 1'b0;
            m_data   <= '0;
            m_next12 <= 1;
            m_burst  <= 0;
            m_rd[0]  <= '0;
            m_rd[1]  <= '0;
            m_rd[2]  <= '0;
        end else if (m_phase == 0) begin
            p0 = bus.p0_rq;
            p1 = bus.p1_w_rq || bus.p1_r_rq;
            p2 = bus.p2_w_rq || bus.p2_r_rq;
            if (p0 || p1 || p2) begin
                if (p0 && !(m_burst == P0_BURST && (p1 || p2))) w = 0;
                else if (p1 && p2) w = m_next12;
                else w = p1 ? 1 : 2;
                m_port  <= w;
                m_phase <= 1;
                if (w == 0) begin
                    m_addr  <= bus.p0_addr[18:0];
                    m_wr    <= 1'b0;
                    m_burst <= (p1 || p2) ? ((m_burst < P0_BURST) ? m_burst + 1 : m_burst) : 0;
                end else begin
                    m_addr   <= (w == 1) ? bus.p1_addr[18:0] : bus.p2_addr[18:0];
                    m_wr     <= (w == 1) ? bus.p1_w_rq : bus.p2_w_rq;
                    m_data   <= (w == 1) ? bus.p1_d_wr : bus.p2_d_wr;
                    m_next12 <= (w == 1) ? 2 : 1;
                    m_burst  <= 0;
                end
            end
        end else if (m_phase <= WAIT + 1) begin
            if (m_phase == WAIT + 1) begin
                if (m_wr) m_mem[m_addr[11:0]] <= m_data;
                else      m_rd[m_port] <= m_mem[m_addr[11:0]];
            end
            m_phase <= m_phase + 1;
        end else begin
            m_phase <= 0;
        end
    end

    always @(negedge clk) begin : compare
        bit in_acc, in_done;
        in_acc  = (m_phase >= 1) && (m_phase <= WAIT + 1);
        in_done = (m_phase == WAIT + 2);
        check("gnt",   32'(gnt),       (m_phase == 0) ? 32'd3 : 32'(m_port));
        check("ce_n",  32'(sram_ce_n), 32'(m_phase == 0));
        check("oe_n",  32'(sram_oe_n), 32'(!(in_acc && !m_wr)));
        check("we_n",  32'(sram_we_n), 32'(!(in_acc && m_wr)));
        check("p0_ack", 32'(bus.p0_ack), 32'(in_done && m_port == 0));
        check("p1_ack", 32'(bus.p1_ack), 32'(in_done && m_port == 1));
        check("p2_ack", 32'(bus.p2_ack), 32'(in_done && m_port == 2));
        check("p0_rd",   32'(bus.p0_rd),   32'(m_rd[0]));
        check("p1_d_rd", 32'(bus.p1_d_rd), 32'(m_rd[1]));
        check("p2_d_rd", 32'(bus.p2_d_rd), 32'(m_rd[2]));
        if (m_phase != 0) check("sram_a", 32'(sram_a), 32'(m_addr));
        if (m_phase == 0)  check("sram_d_idle",  32'(sram_d), 32'hFFFF);
        else if (m_wr)     check("sram_d_write", 32'(sram_d), 32'(m_data));
    end

    // Grant log: one entry per access start.
    int gq[$];
    logic [1:0] prev_gnt = 2'd3;
    always @(negedge clk) begin
        if (gnt != 2'd3 && prev_gnt == 2'd3) gq.push_back(int'(gnt));
        prev_gnt = gnt;
    end

    function automatic int gat(input int i);
        return (gq.size() > i) ? gq[i] : -1;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ack(input int p, output int cyc, output int wl, output int ol,
                            output logic [18:0] a, output logic [15:0] d);
        logic ack;
        cyc = 0; wl = 0; ol = 0; ack = 1'b0;
        while (!ack && cyc < 50) begin
            @(negedge clk);
            cyc++;
            if (!sram_we_n) wl++;
            if (!sram_oe_n) ol++;
            ack = (p == 0) ? bus.p0_ack : (p == 1) ? bus.p1_ack : bus.p2_ack;
        end
        a = sram_a;
        d = sram_d;
        if (!ack) check("ack_timeout", 32'd0, 32'd1);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin : stim
        int cyc, wl, ol, t, n2, cnt;
        logic [18:0] a;
        logic [15:0] d;
        int q1[$];
        int q2[$];
        bit p1_done;

        for (int i = 0; i < 4096; i++) begin
            sram_mem[i] = 16'h0;
            m_mem[i]    = 16'h0;
        end
        sram_mem[12'h456] = 16'h5A5A;
        m_mem[12'h456]    = 16'h5A5A;

        rst_n = 1'b0;
        bus.p0_addr = '0; bus.p0_rq = 1'b0;
        bus.p1_addr = '0; bus.p1_d_wr = '0; bus.p1_w_rq = 1'b0; bus.p1_r_rq = 1'b0;
        bus.p2_addr = '0; bus.p2_d_wr = '0; bus.p2_w_rq = 1'b0; bus.p2_r_rq = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_gnt",  32'(gnt), 32'd3);
        check("rst_ce_n", 32'(sram_ce_n), 32'd1);
        check("rst_we_n", 32'(sram_we_n), 32'd1);
        check("rst_oe_n", 32'(sram_oe_n), 32'd1);
        check("rst_a",    32'(sram_a), 32'd0);
        check("rst_d_z",  32'(sram_d), 32'hFFFF);
        #2 rst_n = 1'b1;

        // A: single port-1 write
        step();
        bus.p1_addr = 24'h000123; bus.p1_d_wr = 16'hBEEF; bus.p1_w_rq = 1'b1;
        wait_ack(1, cyc, wl, ol, a, d);
        check("A_ack_cycle", 32'(cyc), 32'd4);
        check("A_we_low",    32'(wl), 32'd2);
        check("A_addr",      32'(a), 32'h00123);
        check("A_data_done", 32'(d), 32'hBEEF);
        step();
        bus.p1_w_rq = 1'b0;
        check("A_mem", 32'(sram_mem[12'h123]), 32'hBEEF);

        // B: port-2 read, then read data held across a port-1 access
        step();
        bus.p2_addr = 24'h000456; bus.p2_r_rq = 1'b1;
        wait_ack(2, cyc, wl, ol, a, d);
        check("B_oe_low", 32'(ol), 32'd2);
        check("B_rd_ack", 32'(bus.p2_d_rd), 32'h5A5A);
        step();
        bus.p2_r_rq = 1'b0;
        step();
        bus.p1_addr = 24'h000200; bus.p1_d_wr = 16'h1111; bus.p1_w_rq = 1'b1;
        wait_ack(1, cyc, wl, ol, a, d);
        step();
        bus.p1_w_rq = 1'b0;
        check("B_rd_hold", 32'(bus.p2_d_rd), 32'h5A5A);
        step();
        bus.p2_addr = 24'hFF0123; bus.p2_r_rq = 1'b1;
        wait_ack(2, cyc, wl, ol, a, d);
        check("B_rd_back", 32'(bus.p2_d_rd), 32'hBEEF);
        step();
        bus.p2_r_rq = 1'b0;

        // C: ports 1 and 2 continuous
        step();
        gq.delete();
        bus.p1_addr = 24'h000200; bus.p1_r_rq = 1'b1;
        bus.p2_addr = 24'h000456; bus.p2_r_rq = 1'b1;
        n2 = 0; t = 0;
        while (n2 < 2 && t < 60) begin
            @(negedge clk);
            t++;
            if (bus.p1_ack) q1.push_back(t);
            if (bus.p2_ack) begin q2.push_back(t); n2++; end
        end
        step();
        bus.p1_r_rq = 1'b0; bus.p2_r_rq = 1'b0;
        check("C_g0", 32'(gat(0)), 32'd1);
        check("C_g1", 32'(gat(1)), 32'd2);
        check("C_g2", 32'(gat(2)), 32'd1);
        check("C_g3", 32'(gat(3)), 32'd2);
        check("C_p1_period", (q1.size() >= 2) ? 32'(q1[1] - q1[0]) : 32'd0, 32'd8);
        check("C_p2_period", (q2.size() >= 2) ? 32'(q2[1] - q2[0]) : 32'd0, 32'd8);
        check("C_p1_data", 32'(bus.p1_d_rd), 32'h1111);

        // D: video burst limit
        step();
        gq.delete();
        bus.p0_addr = 24'h000456; bus.p0_rq = 1'b1;
        bus.p1_addr = 24'h000123; bus.p1_r_rq = 1'b1;
        t = 0; p1_done = 1'b0;
        while (!p1_done && t < 100) begin
            @(negedge clk);
            t++;
            p1_done = bus.p1_ack;
        end
        step();
        bus.p1_r_rq = 1'b0;
        t = 0;
        while (!(bus.p0_ack && gq.size() >= 6) && t < 100) begin
            @(negedge clk);
            t++;
        end
        step();
        bus.p0_rq = 1'b0;
        check("D_g0", 32'(gat(0)), 32'd0);
        check("D_g1", 32'(gat(1)), 32'd0);
        check("D_g2", 32'(gat(2)), 32'd0);
        check("D_g3", 32'(gat(3)), 32'd0);
        check("D_g4", 32'(gat(4)), 32'd1);
        check("D_g5", 32'(gat(5)), 32'd0);
        check("D_p0_rd", 32'(bus.p0_rd), 32'h5A5A);
        check("D_p1_rd", 32'(bus.p1_d_rd), 32'hBEEF);

        // E: write and read requested together -> one write
        step();
        bus.p1_addr = 24'h000300; bus.p1_d_wr = 16'hCAFE;
        bus.p1_w_rq = 1'b1; bus.p1_r_rq = 1'b1;
        wait_ack(1, cyc, wl, ol, a, d);
        check("E_we_low", 32'(wl), 32'd2);
        check("E_oe_low", 32'(ol), 32'd0);
        step();
        bus.p1_w_rq = 1'b0; bus.p1_r_rq = 1'b0;
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus.p1_ack) cnt++;
        end
        check("E_single_ack", 32'(cnt), 32'd0);
        step();
        bus.p2_addr = 24'h000300; bus.p2_r_rq = 1'b1;
        wait_ack(2, cyc, wl, ol, a, d);
        check("E_readback", 32'(bus.p2_d_rd), 32'hCAFE);
        step();
        bus.p2_r_rq = 1'b0;

        // F: reset during the strobe phase of a write
        step();
        bus.p2_addr = 24'h000400; bus.p2_d_wr = 16'h7777; bus.p2_w_rq = 1'b1;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (sram_we_n && t < 20);
        #2 rst_n = 1'b0;
        #1;
        check("F_we_n",  32'(sram_we_n), 32'd1);
        check("F_ce_n",  32'(sram_ce_n), 32'd1);
        check("F_d_z",   32'(sram_d), 32'hFFFF);
        check("F_gnt",   32'(gnt), 32'd3);
        check("F_ack",   32'(bus.p2_ack), 32'd0);
        check("F_rd_clr", 32'(bus.p2_d_rd), 32'd0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        wait_ack(2, cyc, wl, ol, a, d);
        check("F_we_low", 32'(wl), 32'd2);
        step();
        bus.p2_w_rq = 1'b0;
        check("F_mem", 32'(sram_mem[12'h400]), 32'h7777);

        repeat (4) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares one external 16-bit asynchronous SRAM between three requesters.
- Port 0 is the video fetch: read-only, fixed high priority, with a starvation guard.
- Ports 1 and 2 are read/write ports (port 1 = AVR debug-access bridge, port 2 = CPU), served round-robin between themselves.
- Sits between the requesters and the SRAM pins, runs the SRAM access timing, and returns a one-cycle acknowledge per access.

Parameters:
- ADDR_W, 24, requester address width.
- SRAM_AW, 19, SRAM word-address width; uses addr[SRAM_AW-1:0], upper bits ignored.
- WAIT, 1, extra access cycles beyond one (0..7).
- P0_BURST, 4, max consecutive port-0 grants while port 1/2 pending (1..15).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- p0_addr  in  ADDR_W  video read address.
- p0_rq  in  1  video read request.
- p0_ack  out  1  one-cycle acknowledge.
- p0_rd  out  16  video read data.
- p1_addr  in  ADDR_W  port-1 address.
- p1_d_wr  in  16  port-1 write data.
- p1_w_rq  in  1  port-1 write request.
- p1_r_rq  in  1  port-1 read request.
- p1_ack  out  1  one-cycle acknowledge.
- p1_d_rd  out  16  port-1 read data.
- p2_addr, p2_d_wr, p2_w_rq, p2_r_rq, p2_ack, p2_d_rd: as port 1.
- sram_a  out  SRAM_AW  SRAM address.
- sram_d  inout  16  SRAM data bus.
- sram_ce_n  out  1  chip enable.
- sram_oe_n  out  1  output enable.
- sram_we_n  out  1  write enable.
- gnt  out  2  current grant: 0/1/2 = port, 3 = none.

Behaviour:
- One clock (clk). Reset is asynchronous, active-low (rst_n).
- Reset values, applied immediately and aborting any access without ack:
  - sram_ce_n/oe_n/we_n = 1, sram_d = Z, sram_a = 0
  - all acks = 0, all rd regs = 0, gnt = 3
  - rr pointer favours port 1, port-0 burst counter = 0, state IDLE
- Requester contract: hold request, addr and d_wr stable until ack; ack lasts exactly one clk. A request still high the cycle after ack is treated as a new access.
- If w_rq and r_rq are both high on one port, the write wins.
- Read data is registered per port, updated only on that port's read completion, and valid in the ack cycle. It holds until the port's next read.
- FSM states:
  - IDLE: if any request, pick a winner, latch port, addr, data and direction, set gnt, go to ACC with cnt = WAIT. Otherwise stay, gnt = 3.
  - ACC: ce_n = 0, sram_a driven. Read: oe_n = 0. Write: we_n = 0, sram_d driven. Decrement cnt; at cnt == 0, a read captures sram_d into the port rd reg; go to DONE.
  - DONE: we_n = 1, oe_n = 1, ce_n = 0. A write keeps driving sram_d (hold time). Pulse ack of the granted port, then go to IDLE.
- Access takes WAIT+3 clk from the request seen in IDLE to the cycle after ack. IDLE always costs one cycle, so accesses are never back-to-back and there is no bus contention between a read and a following write.
- Winner selection (combinational, from current requests):
  - Port 0 wins, unless burst counter == P0_BURST and port 1 or 2 is pending.
  - Otherwise port 1 vs 2 by rr pointer. The pointer flips to the other port after each grant to 1 or 2.
- Burst counter:
  - +1 on each port-0 grant while port 1/2 pending, saturating at P0_BURST.
  - Cleared on any port-1/2 grant, or when a port-0 grant occurs with nothing else pending.
- Requests that drop before grant are ignored; there is no abort once granted.

Decomposition:
- Package mem_arb_pkg holds:
  - state encoding IDLE/ACC/DONE
  - port IDs P_VID = 0, P_DAP = 1, P_CPU = 2, GNT_NONE = 3
- Sub-module mem_arb_pick is purely combinational. Inputs: three pending flags, rr pointer, burst-limit flag. Outputs: winner ID and valid.

Test Plan:
- Single port-1 write, addr 0x000123, data 0xBEEF, WAIT=1 -> we_n low exactly 2 clk, sram_a = 0x00123, sram_d = 0xBEEF through DONE; p1_ack one clk, 4 clk after request.
- Port-2 read at 0x00456, SRAM model returns 0x5A5A -> oe_n low 2 clk; p2_d_rd = 0x5A5A in ack cycle, held across a later port-1 access.
- Ports 1 and 2 request continuously -> grants alternate 1, 2, 1, 2; each port acks every 8 clk.
- Port 0 continuous plus port 1 pending, P0_BURST=4 -> grant sequence 0, 0, 0, 0, 1, 0, ...
- Port 1 with w_rq and r_rq both high -> write performed, single ack.
- rst_n low during ACC of a write -> we_n = 1 and sram_d = Z immediately, no ack; after release a still-held request is served from IDLE.
